// File: rtl/maze_ctrl_pkg.sv
// Shared types and constants for the maze game controller.
package maze_ctrl_pkg;

    // Top-level game FSM states. The encoding is visible on o_State.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_CHECK    = 3'd2,
        ST_RESOLVE  = 3'd3,
        ST_MOVE     = 3'd4,
        ST_LV_CHECK = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Direction codes held in the pending register.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Tile every level starts on.
    localparam int START_X = 1;
    localparam int START_Y = 1;

    // Key bits are {L,U,D,R}; when several are pressed together the
    // leftmost bit wins. Callers only use the result when keys != 0.
    function automatic dir_e dir_prio(input logic [3:0] keys);
        if (keys[3])      return DIR_LEFT;
        else if (keys[2]) return DIR_UP;
        else if (keys[1]) return DIR_DOWN;
        else              return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/maze_ctrl_if.sv
// Map/level ROM port of the maze controller.
// The read port is a strobe with no back-pressure: o_MapRdEn is high for
// one cycle with o_MapX/o_MapY valid, and the ROM returns i_MapWall for
// that address on the following cycle. i_GoalX/i_GoalY are the goal tile
// of the level currently shown on o_Level and are treated as static.
interface maze_ctrl_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           o_MapRdEn;
    logic [X_W-1:0] o_MapX;
    logic [Y_W-1:0] o_MapY;
    logic           i_MapWall;
    logic [X_W-1:0] i_GoalX;
    logic [Y_W-1:0] i_GoalY;

    modport master (
        output o_MapRdEn, o_MapX, o_MapY,
        input  i_MapWall, i_GoalX, i_GoalY
    );

    modport slave (
        input  o_MapRdEn, o_MapX, o_MapY,
        output i_MapWall, i_GoalX, i_GoalY
    );
endinterface

// File: rtl/maze_ctrl_dir_latch.sv
// Direction intake: priority-encodes a key request and keeps it in a
// single-entry pending register until the game FSM consumes it.
module maze_dir_latch
    import maze_ctrl_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Dir,
    input  logic       i_Wr,
    input  logic       i_Consume,
    input  logic       i_Clr,
    output logic       o_Valid,
    output dir_e       o_Code
);

    logic valid_q, valid_d;
    dir_e code_q, code_d;

    // Clear beats a new write; a write in the consume cycle becomes the
    // next pending entry instead of being lost.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        if (i_Clr) begin
            valid_d = 1'b0;
        end else if (i_Wr) begin
            valid_d = 1'b1;
            code_d  = dir_prio(i_Dir);
        end else if (i_Consume) begin
            valid_d = 1'b0;
        end
    end

    // Pending register.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            valid_q <= 1'b0;
            code_q  <= DIR_LEFT;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign o_Valid = valid_q;
    assign o_Code  = code_q;

endmodule

// File: rtl/maze_ctrl.sv
// Maze game controller: level, player position, move counter and
// completion detection, with walls read through a 1-cycle map ROM port.
module maze_ctrl
    import maze_ctrl_pkg::*;
#(
    parameter int COLS     = 40,
    parameter int ROWS     = 30,
    parameter int N_LEVELS = 3,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int LV_W     = 2,
    parameter int MC_W     = 10
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Start,
    input  logic [3:0]      i_Dir,
    input  logic            i_DirValid,
    input  logic            i_FrameDone,
    maze_ctrl_if.master     map_bus,
    output logic [LV_W-1:0] o_Level,
    output logic [X_W-1:0]  o_PlayerX,
    output logic [Y_W-1:0]  o_PlayerY,
    output logic [MC_W-1:0] o_MoveCount,
    output logic [2:0]      o_State,
    output logic            o_Running,
    output logic            o_LevelDone,
    output logic            o_GameDone
);

    // Bounds in the one-bit-wider target arithmetic.
    localparam logic [X_W:0] COLS_LIM = (X_W + 1)'(COLS);
    localparam logic [Y_W:0] ROWS_LIM = (Y_W + 1)'(ROWS);

    state_e            state_q, state_d;
    logic [LV_W-1:0]   level_q, level_d;
    logic [X_W-1:0]    px_q, px_d;
    logic [Y_W-1:0]    py_q, py_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [X_W-1:0]    map_x_q, map_x_d;
    logic [Y_W-1:0]    map_y_q, map_y_d;
    logic              rd_en_q, rd_en_d;
    logic              oob_q, oob_d;
    logic              lvl_done_q, lvl_done_d;
    logic              game_done_q, game_done_d;

    logic              intake_en, dl_wr, dl_consume, dl_clr;
    logic              pend_valid;
    dir_e              pend_code;
    logic [X_W:0]      tgt_x;
    logic [Y_W:0]      tgt_y;
    logic              tgt_oob;

    assign intake_en = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign dl_wr     = intake_en && i_DirValid && (i_Dir != 4'b0000);

    maze_dir_latch u_dir_latch (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Dir     (i_Dir),
        .i_Wr      (dl_wr),
        .i_Consume (dl_consume),
        .i_Clr     (dl_clr),
        .o_Valid   (pend_valid),
        .o_Code    (pend_code)
    );

    // Neighbour tile for the pending direction. Stepping left/up from 0
    // wraps to all-ones in the widened value, so one bound check covers
    // both edges without any wrap-around onto the far side of the map.
    always_comb begin
        tgt_x = {1'b0, px_q};
        tgt_y = {1'b0, py_q};
        unique case (pend_code)
            DIR_LEFT:  tgt_x = {1'b0, px_q} - (X_W + 1)'(1);
            DIR_UP:    tgt_y = {1'b0, py_q} - (Y_W + 1)'(1);
            DIR_DOWN:  tgt_y = {1'b0, py_q} + (Y_W + 1)'(1);
            DIR_RIGHT: tgt_x = {1'b0, px_q} + (X_W + 1)'(1);
        endcase
        tgt_oob = (tgt_x >= COLS_LIM) || (tgt_y >= ROWS_LIM);
    end

    // Game FSM next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        px_d        = px_q;
        py_d        = py_q;
        mc_d        = mc_q;
        map_x_d     = map_x_q;
        map_y_d     = map_y_q;
        oob_d       = oob_q;
        rd_en_d     = 1'b0;
        lvl_done_d  = 1'b0;
        game_done_d = 1'b0;
        dl_consume  = 1'b0;
        dl_clr      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_Start) begin
                    state_d = ST_WAIT;
                    level_d = '0;
                    px_d    = X_W'(START_X);
                    py_d    = Y_W'(START_Y);
                    mc_d    = '0;
                    dl_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_FrameDone && pend_valid) begin
                    dl_consume = 1'b1;
                    map_x_d    = tgt_x[X_W-1:0];
                    map_y_d    = tgt_y[Y_W-1:0];
                    oob_d      = tgt_oob;
                    rd_en_d    = !tgt_oob;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (oob_q || map_bus.i_MapWall) state_d = ST_WAIT;
                else                            state_d = ST_MOVE;
            end
            ST_MOVE: begin
                px_d    = map_x_q;
                py_d    = map_y_q;
                if (mc_q != '1) mc_d = mc_q + MC_W'(1);
                state_d = ST_LV_CHECK;
            end
            ST_LV_CHECK: begin
                state_d = ST_WAIT;
                if ((px_q == map_bus.i_GoalX) && (py_q == map_bus.i_GoalY)) begin
                    if (level_q == LV_W'(N_LEVELS - 1)) begin
                        game_done_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        level_d    = level_q + LV_W'(1);
                        px_d       = X_W'(START_X);
                        py_d       = Y_W'(START_Y);
                        dl_clr     = 1'b1;
                        lvl_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            px_q        <= '0;
            py_q        <= '0;
            mc_q        <= '0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            rd_en_q     <= 1'b0;
            oob_q       <= 1'b0;
            lvl_done_q  <= 1'b0;
            game_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            px_q        <= px_d;
            py_q        <= py_d;
            mc_q        <= mc_d;
            map_x_q     <= map_x_d;
            map_y_q     <= map_y_d;
            rd_en_q     <= rd_en_d;
            oob_q       <= oob_d;
            lvl_done_q  <= lvl_done_d;
            game_done_q <= game_done_d;
        end
    end

    assign map_bus.o_MapRdEn = rd_en_q;
    assign map_bus.o_MapX    = map_x_q;
    assign map_bus.o_MapY    = map_y_q;
    assign o_Level           = level_q;
    assign o_PlayerX         = px_q;
    assign o_PlayerY         = py_q;
    assign o_MoveCount       = mc_q;
    assign o_State           = state_q;
    assign o_Running         = intake_en;
    assign o_LevelDone       = lvl_done_q;
    assign o_GameDone        = game_done_q;

endmodule
